// File: rtl/calc_controller.sv
// Keypad calculator sequencer: collects two decimal operands and an operator,
// launches the arithmetic datapath, waits for completion and holds the result.
//
// state  | meaning
// ENTER1 | collecting operand 1 digits
// ENTER2 | operator chosen, collecting operand 2 digits
// EXEC   | datapath launched, waiting for alu_done
// SHOW   | result latched for display
// ERR    | datapath timed out, waiting for clear
module calc_controller #(
    parameter int DIGITS  = 2,
    parameter int OPW     = 7,
    parameter int RW      = 14,
    parameter int TIMEOUT = 15
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           key_valid,
    input  logic [3:0]     key_code,
    input  logic           alu_done,
    input  logic [RW-1:0]  alu_result,
    output logic [OPW-1:0] in1,
    output logic [OPW-1:0] in2,
    output logic [1:0]     op_sel,
    output logic           alu_start,
    output logic [RW-1:0]  result,
    output logic           display_on,
    output logic [2:0]     curr_state,
    output logic           error
);

    localparam logic [2:0] ENTER1 = 3'd0;
    localparam logic [2:0] ENTER2 = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] SHOW   = 3'd3;
    localparam logic [2:0] ERR    = 3'd4;

    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] MAX_DIGITS  = CW'(DIGITS);
    localparam logic [TW-1:0] TIMER_LOAD  = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] CHAIN_LIMIT = RW'(10 ** DIGITS);

    logic [CW-1:0]  cnt1;
    logic [CW-1:0]  cnt2;
    logic [TW-1:0]  timer;

    logic           is_digit;
    logic           is_op;
    logic           is_clr;
    logic           is_eq;
    logic           key_live;
    logic [1:0]     op_code;
    logic [OPW-1:0] digit_ext;
    logic [OPW-1:0] acc1;
    logic [OPW-1:0] acc2;

    always_comb begin
        is_digit  = key_valid && (key_code <= 4'd9);
        is_op     = key_valid && (key_code >= 4'd10) && (key_code <= 4'd12);
        is_clr    = key_valid && (key_code == 4'd13);
        is_eq     = key_valid && (key_code == 4'd14);
        key_live  = key_valid && (key_code != 4'd13) && (key_code != 4'd15);
        // codes 10..12 have low bits 2,3,0; adding 2 mod 4 yields 0,1,2
        op_code   = key_code[1:0] + 2'd2;
        digit_ext = {{(OPW-4){1'b0}}, key_code};
        acc1      = in1 * OPW'(10) + digit_ext;
        acc2      = in2 * OPW'(10) + digit_ext;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            curr_state <= ENTER1;
            in1        <= '0;
            in2        <= '0;
            op_sel     <= '0;
            result     <= '0;
            alu_start  <= 1'b0;
            display_on <= 1'b0;
            error      <= 1'b0;
            cnt1       <= '0;
            cnt2       <= '0;
            timer      <= '0;
        end else begin
            alu_start <= 1'b0;
            if (is_clr) begin
                curr_state <= ENTER1;
                in1        <= '0;
                in2        <= '0;
                op_sel     <= '0;
                result     <= '0;
                display_on <= 1'b0;
                error      <= 1'b0;
                cnt1       <= '0;
                cnt2       <= '0;
                timer      <= '0;
            end else begin
                if (key_live) display_on <= 1'b1;
                case (curr_state)
                    ENTER1: begin
                        if (is_digit && (cnt1 < MAX_DIGITS)) begin
                            in1  <= acc1;
                            cnt1 <= cnt1 + CW'(1);
                        end else if (is_op) begin
                            op_sel     <= op_code;
                            in2        <= '0;
                            cnt2       <= '0;
                            curr_state <= ENTER2;
                        end
                    end
                    ENTER2: begin
                        if (is_digit && (cnt2 < MAX_DIGITS)) begin
                            in2  <= acc2;
                            cnt2 <= cnt2 + CW'(1);
                        end else if (is_op && (cnt2 == '0)) begin
                            op_sel <= op_code;
                        end else if (is_eq) begin
                            alu_start  <= 1'b1;
                            timer      <= TIMER_LOAD;
                            curr_state <= EXEC;
                        end
                    end
                    EXEC: begin
                        // a completion on the expiry cycle still counts
                        if (alu_done) begin
                            result     <= alu_result;
                            curr_state <= SHOW;
                        end else if (timer == '0) begin
                            error      <= 1'b1;
                            display_on <= 1'b1;
                            curr_state <= ERR;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    SHOW: begin
                        if (is_digit) begin
                            in1        <= digit_ext;
                            cnt1       <= CW'(1);
                            in2        <= '0;
                            cnt2       <= '0;
                            curr_state <= ENTER1;
                        end else if (is_op && (result < CHAIN_LIMIT)) begin
                            in1        <= result[OPW-1:0];
                            op_sel     <= op_code;
                            in2        <= '0;
                            cnt2       <= '0;
                            curr_state <= ENTER2;
                        end else if (is_eq) begin
                            alu_start  <= 1'b1;
                            timer      <= TIMER_LOAD;
                            curr_state <= EXEC;
                        end
                    end
                    ERR: begin
                        error      <= 1'b1;
                        display_on <= 1'b1;
                    end
                    default: curr_state <= ENTER1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller: a cycle-by-cycle vector table plus
// hand-written sequences for timeout, clear/done collisions and async reset.
module tb_calc_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        alu_done = 1'b0;
    logic [13:0] alu_result = '0;
    logic [6:0]  in1, in2;
    logic [1:0]  op_sel;
    logic        alu_start;
    logic [13:0] result;
    logic        display_on;
    logic [2:0]  curr_state;
    logic        error;

    int errors = 0;
    int checks = 0;

    calc_controller dut (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .alu_done(alu_done), .alu_result(alu_result), .in1(in1), .in2(in2),
        .op_sel(op_sel), .alu_start(alu_start), .result(result),
        .display_on(display_on), .curr_state(curr_state), .error(error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int kc;   // -1 = no key
        int dn;
        int ar;
        int st, i1, i2, op, as, rs, dp, er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int kc, int dn, int ar, int st, int i1, int i2,
                                int op, int as, int rs, int dp, int er);
        vec_t v;
        v.kc = kc; v.dn = dn; v.ar = ar;
        v.st = st; v.i1 = i1; v.i2 = i2; v.op = op;
        v.as = as; v.rs = rs; v.dp = dp; v.er = er;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, int st, int i1, int i2, int op, int as,
                             int rs, int dp, int er);
        check({tag, " state"}, int'(curr_state), st);
        check({tag, " in1"}, int'(in1), i1);
        check({tag, " in2"}, int'(in2), i2);
        check({tag, " op_sel"}, int'(op_sel), op);
        check({tag, " alu_start"}, int'(alu_start), as);
        check({tag, " result"}, int'(result), rs);
        check({tag, " display_on"}, int'(display_on), dp);
        check({tag, " error"}, int'(error), er);
    endtask

    // One clock: drive at negedge, let the edge register it, release pulses.
    task automatic step(int kc, int dn, int ar);
        @(negedge clock);
        key_valid  = (kc >= 0);
        key_code   = (kc >= 0) ? 4'(kc) : 4'd0;
        alu_done   = (dn != 0);
        alu_result = 14'(ar);
        @(posedge clock);
        #1;
        key_valid = 1'b0;
        alu_done  = 1'b0;
    endtask

    initial begin
        // keys 1,2,A,3,4,= then result after 3 cycles
        vecs.push_back(mk( 1, 0, 0,     0, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk( 2, 0, 0,     0, 12, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(10, 0, 0,     1, 12, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk( 3, 0, 0,     1, 12, 3, 0, 0, 0, 1, 0));
        vecs.push_back(mk( 4, 0, 0,     1, 12, 34, 0, 0, 0, 1, 0));
        vecs.push_back(mk(14, 0, 0,     2, 12, 34, 0, 1, 0, 1, 0));
        vecs.push_back(mk(-1, 0, 0,     2, 12, 34, 0, 0, 0, 1, 0));
        vecs.push_back(mk(-1, 0, 0,     2, 12, 34, 0, 0, 0, 1, 0));
        vecs.push_back(mk(-1, 1, 46,    3, 12, 34, 0, 0, 46, 1, 0));
        vecs.push_back(mk(-1, 0, 0,     3, 12, 34, 0, 0, 46, 1, 0));
        // chain B,5,= ; sub gives 5-46 = -41
        vecs.push_back(mk(11, 0, 0,     1, 46, 0, 1, 0, 46, 1, 0));
        vecs.push_back(mk( 5, 0, 0,     1, 46, 5, 1, 0, 46, 1, 0));
        vecs.push_back(mk(14, 0, 0,     2, 46, 5, 1, 1, 46, 1, 0));
        vecs.push_back(mk(-1, 1, 16343, 3, 46, 5, 1, 0, 16343, 1, 0));
        vecs.push_back(mk(10, 0, 0,     3, 46, 5, 1, 0, 16343, 1, 0));
        vecs.push_back(mk(13, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
        // 9,9,9,C,9,9,9,= with third digits dropped
        vecs.push_back(mk( 9, 0, 0,     0, 9, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk( 9, 0, 0,     0, 99, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk( 9, 0, 0,     0, 99, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(12, 0, 0,     1, 99, 0, 2, 0, 0, 1, 0));
        vecs.push_back(mk( 9, 0, 0,     1, 99, 9, 2, 0, 0, 1, 0));
        vecs.push_back(mk( 9, 0, 0,     1, 99, 99, 2, 0, 0, 1, 0));
        vecs.push_back(mk( 9, 0, 0,     1, 99, 99, 2, 0, 0, 1, 0));
        vecs.push_back(mk(14, 0, 0,     2, 99, 99, 2, 1, 0, 1, 0));
        vecs.push_back(mk(-1, 1, 9801,  3, 99, 99, 2, 0, 9801, 1, 0));
        vecs.push_back(mk(10, 0, 0,     3, 99, 99, 2, 0, 9801, 1, 0));
        vecs.push_back(mk(15, 0, 0,     3, 99, 99, 2, 0, 9801, 1, 0));
        vecs.push_back(mk(13, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0));
        // stray alu_done outside EXEC, then A then B before any digit
        vecs.push_back(mk(-1, 1, 555,   0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(10, 0, 0,     1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(11, 0, 0,     1, 0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk( 7, 0, 0,     1, 0, 7, 1, 0, 0, 1, 0));
        vecs.push_back(mk(12, 0, 0,     1, 0, 7, 1, 0, 0, 1, 0));
        vecs.push_back(mk(14, 0, 0,     2, 0, 7, 1, 1, 0, 1, 0));
        vecs.push_back(mk(-1, 1, 7,     3, 0, 7, 1, 0, 7, 1, 0));
        // equals in SHOW relaunches, digit in SHOW starts a new operand
        vecs.push_back(mk(14, 0, 0,     2, 0, 7, 1, 1, 7, 1, 0));
        vecs.push_back(mk(-1, 1, 7,     3, 0, 7, 1, 0, 7, 1, 0));
        vecs.push_back(mk( 8, 0, 0,     0, 8, 0, 1, 0, 7, 1, 0));
        vecs.push_back(mk(14, 0, 0,     0, 8, 0, 1, 0, 7, 1, 0));
        vecs.push_back(mk( 2, 0, 0,     0, 82, 0, 1, 0, 7, 1, 0));
        vecs.push_back(mk( 3, 0, 0,     0, 82, 0, 1, 0, 7, 1, 0));
        vecs.push_back(mk(13, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0));

        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].kc, vecs[i].dn, vecs[i].ar);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].i1, vecs[i].i2,
                      vecs[i].op, vecs[i].as, vecs[i].rs, vecs[i].dp, vecs[i].er);
        end

        // timeout: alu_done never arrives
        step(1, 0, 0); step(10, 0, 0); step(14, 0, 0);
        check("to start", int'(alu_start), 1);
        for (int i = 0; i < 14; i++) step(-1, 0, 0);
        check("to last exec state", int'(curr_state), 2);
        check("to last exec error", int'(error), 0);
        step(-1, 0, 0);
        check("to err state", int'(curr_state), 4);
        check("to err error", int'(error), 1);
        check("to err display", int'(display_on), 1);
        step(5, 0, 0);
        check("err digit ignored", int'(curr_state), 4);
        step(14, 1, 33);
        check("err eq ignored", int'(curr_state), 4);
        check("err done ignored", int'(result), 0);
        step(13, 0, 0);
        check_all("err clear", 0, 0, 0, 0, 0, 0, 0, 0);

        // alu_done on the expiry cycle is accepted
        step(1, 0, 0); step(10, 0, 0); step(14, 0, 0);
        for (int i = 0; i < 14; i++) step(-1, 0, 0);
        step(-1, 1, 77);
        check("expiry done state", int'(curr_state), 3);
        check("expiry done result", int'(result), 77);
        check("expiry done error", int'(error), 0);
        step(13, 0, 0);

        // clear and alu_done together in EXEC
        step(2, 0, 0); step(12, 0, 0); step(3, 0, 0); step(14, 0, 0);
        step(13, 1, 99);
        check_all("clr+done", 0, 0, 0, 0, 0, 0, 0, 0);
        step(-1, 1, 99);
        check("late done result", int'(result), 0);
        check("late done state", int'(curr_state), 0);

        // async reset mid-EXEC
        step(4, 0, 0); step(10, 0, 0); step(6, 0, 0); step(14, 0, 0);
        check("pre-reset state", int'(curr_state), 2);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check_all("async reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        step(-1, 1, 10);
        check("post-reset done state", int'(curr_state), 0);
        check("post-reset done result", int'(result), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
